// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants, state encoding and access-check helpers for lsu_ctrl
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STORE,
        S_RMW_RD,
        S_RMW_WR,
        S_RESP
    } lsu_state_t;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
        case (funct3)
            F3_H, F3_HU: return lane[0];
            F3_W:        return lane != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    // Stores have no unsigned variants, so BU/HU encodings are illegal with we=1.
    function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
        if (we)
            return !(funct3 inside {F3_B, F3_H, F3_W});
        return !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - lane extraction/extension for loads and lane merge for sub-word stores
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    input  logic [31:0] old,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_byte = word[{lane, 3'b000} +: 8];
    assign ld_half = word[{lane[1], 4'b0000} +: 16];

    always_comb begin
        rdata = word;
        case (funct3)
            F3_B:    rdata = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   rdata = {24'h000000, ld_byte};
            F3_H:    rdata = {{16{ld_half[15]}}, ld_half};
            F3_HU:   rdata = {16'h0000, ld_half};
            default: rdata = word;
        endcase
    end

    always_comb begin
        merged = old;
        case (funct3)
            F3_B:    merged[{lane, 3'b000} +: 8]     = wdata[7:0];
            F3_H:    merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - single-outstanding load/store controller in front of Data_Memory
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_A,
    output logic              mem_WE,
    output logic [DATA_W-1:0] mem_WD,
    input  logic [DATA_W-1:0] mem_RD
);

    lsu_state_t        state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        f3_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] old_q;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] st_merged;
    logic              accept;
    logic              req_err;

    assign accept  = req_valid && req_ready;
    assign req_err = is_illegal(req_we, req_funct3) || is_misaligned(req_funct3, req_addr[1:0]);
    assign mem_A   = {addr_q[ADDR_W-1:2], 2'b00};

    lsu_align u_align (
        .funct3 (f3_q),
        .lane   (addr_q[1:0]),
        .word   (mem_RD),
        .old    (old_q),
        .wdata  (wdata_q),
        .rdata  (ld_data),
        .merged (st_merged)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_WE    = 1'b0;
        mem_WD    = '0;
        case (state)
            S_IDLE: begin
                req_ready = rst;
                if (accept) begin
                    if (req_err)
                        state_nxt = S_RESP;
                    else if (!req_we)
                        state_nxt = S_LOAD;
                    else if (req_funct3 == F3_W)
                        state_nxt = S_STORE;
                    else
                        state_nxt = S_RMW_RD;
                end
            end
            S_LOAD:   state_nxt = S_RESP;
            S_STORE: begin
                mem_WE    = 1'b1;
                mem_WD    = wdata_q;
                state_nxt = S_RESP;
            end
            S_RMW_RD: state_nxt = S_RMW_WR;
            S_RMW_WR: begin
                mem_WE    = 1'b1;
                mem_WD    = st_merged;
                state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Response fields are cleared on accept so stores and errors report zero data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q    <= '0;
            f3_q      <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            old_q     <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q    <= req_addr;
                f3_q      <= req_funct3;
                we_q      <= req_we;
                wdata_q   <= req_wdata;
                rsp_rdata <= '0;
                rsp_err   <= req_err;
            end
            if (state == S_LOAD && !we_q)
                rsp_rdata <= ld_data;
            if (state == S_RMW_RD)
                old_q <= mem_RD;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed scoreboard bench for lsu_ctrl with a behavioural Data_Memory
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_A, mem_WD, mem_RD;
    logic        mem_WE;

    logic [31:0] mem [0:255];
    logic [32:0] sb_q [$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_a, last_wd;

    always #5 clk = ~clk;

    assign mem_RD = mem[mem_A[9:2]];
    always @(posedge clk) if (mem_WE) mem[mem_A[9:2]] <= mem_WD;

    lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_A      (mem_A),
        .mem_WE     (mem_WE),
        .mem_WD     (mem_WD),
        .mem_RD     (mem_RD)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called right after a falling edge; returns right after a falling edge.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input int exp_we, input int hold);
        int          n;
        int          lat;
        int          we_cnt;
        logic        a_ok;
        logic [32:0] exp;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        sb_q.push_back({exp_err, exp_rdata});
        @(negedge clk);
        req_valid  = 1'b0;
        req_we     = ~we;
        req_funct3 = 3'b111;
        req_addr   = 32'hFFFF_FFF3;
        req_wdata  = 32'hDEAD_BEEF;
        lat    = 0;
        we_cnt = 0;
        a_ok   = 1'b1;
        while (!rsp_valid && lat < 20) begin
            if (mem_A !== {addr[31:2], 2'b00}) a_ok = 1'b0;
            if (mem_WE) begin
                we_cnt++;
                last_a  = mem_A;
                last_wd = mem_WD;
            end
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " we_cycles"}, we_cnt, exp_we);
        chk({tag, " mem_A_stable"}, {31'd0, a_ok}, 32'd1);
        chk({tag, " mem_A_resp"}, mem_A, {addr[31:2], 2'b00});
        for (int i = 0; i < hold; i++) begin
            chk({tag, " hold_valid"}, {31'd0, rsp_valid}, 32'd1);
            chk({tag, " hold_rdata"}, rsp_rdata, exp_rdata);
            chk({tag, " hold_ready"}, {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        chk({tag, " resp_req_ready"}, {31'd0, req_ready}, 32'd0);
        chk({tag, " resp_mem_WE"}, {31'd0, mem_WE}, 32'd0);
        if (sb_q.size() == 0) begin
            chk({tag, " sb_empty"}, 32'd0, 32'd1);
        end else begin
            exp = sb_q.pop_front();
            chk({tag, " rsp_rdata"}, rsp_rdata, exp[31:0]);
            chk({tag, " rsp_err"}, {31'd0, rsp_err}, {31'd0, exp[32]});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, " post_valid"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        logic ok;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[32'h1C >> 2] = 32'h0000_0020;
        rst        = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h64;
        req_wdata  = 32'hFFFF_FFFF;
        rsp_ready  = 1'b1;

        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 ||
                rsp_err !== 1'b0 || mem_A !== 32'h0 || mem_WE !== 1'b0 || mem_WD !== 32'h0)
                ok = 1'b0;
        end
        chk("reset_outputs", {31'd0, ok}, 32'd1);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        chk("reset_release_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_release_mem", mem[32'h64 >> 2], 32'h0);

        do_req("LW_1C", 1'b0, 3'b010, 32'h1C, 32'h0, 32'h0000_0020, 1'b0, 1, 0, 0);
        do_req("SW_64", 1'b1, 3'b010, 32'h64, 32'h1234_5678, 32'h0, 1'b0, 1, 1, 0);
        chk("SW_64 addr", last_a, 32'h64);
        chk("SW_64 wd", last_wd, 32'h1234_5678);
        do_req("LB_67", 1'b0, 3'b000, 32'h67, 32'h0, 32'h0000_0012, 1'b0, 1, 0, 0);
        do_req("LH_66", 1'b0, 3'b001, 32'h66, 32'h0, 32'h0000_1234, 1'b0, 1, 0, 0);
        do_req("LHU_64", 1'b0, 3'b101, 32'h64, 32'h0, 32'h0000_5678, 1'b0, 1, 0, 0);
        do_req("SB_65", 1'b1, 3'b000, 32'h65, 32'hFFFF_FFAB, 32'h0, 1'b0, 2, 1, 0);
        chk("SB_65 wd", last_wd, 32'h1234_AB78);
        chk("SB_65 mem", mem[32'h64 >> 2], 32'h1234_AB78);
        do_req("LB_65", 1'b0, 3'b000, 32'h65, 32'h0, 32'hFFFF_FFAB, 1'b0, 1, 0, 0);
        do_req("LBU_65", 1'b0, 3'b100, 32'h65, 32'h0, 32'h0000_00AB, 1'b0, 1, 0, 0);
        do_req("ERR_LW_62", 1'b0, 3'b010, 32'h62, 32'h0, 32'h0, 1'b1, 0, 0, 0);
        do_req("ERR_SH_63", 1'b1, 3'b001, 32'h63, 32'h5555_5555, 32'h0, 1'b1, 0, 0, 0);
        do_req("ERR_F3_011", 1'b0, 3'b011, 32'h64, 32'h0, 32'h0, 1'b1, 0, 0, 0);
        chk("ERR mem_unchanged", mem[32'h64 >> 2], 32'h1234_AB78);
        do_req("BP_LW_64", 1'b0, 3'b010, 32'h64, 32'h0, 32'h1234_AB78, 1'b0, 1, 0, 3);

        // Reset asserted while the merged word is being driven
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h64;
        req_wdata  = 32'h0000_00EE;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("RST_mid in_rmw_wr", {31'd0, mem_WE}, 32'd1);
        rst = 1'b0;
        #1;
        chk("RST_mid mem_WE_drop", {31'd0, mem_WE}, 32'd0);
        chk("RST_mid req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) ok = 1'b0;
        end
        chk("RST_mid no_rsp", {31'd0, ok}, 32'd1);
        chk("RST_mid mem", mem[32'h64 >> 2], 32'h1234_AB78);
        do_req("POST_LW_64", 1'b0, 3'b010, 32'h64, 32'h0, 32'h1234_AB78, 1'b0, 1, 0, 0);
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
